// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master slice.
// Contents:
//   spi_state_t  - transfer FSM state encoding
//   SPI_N        - default word width
//   SPI_CLK_DIV  - default sclk half-period in clk cycles
//   spi_clog2()  - ceiling log2 used to size counters
package spi_pkg;

    localparam int unsigned SPI_N       = 8;
    localparam int unsigned SPI_CLK_DIV = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LEAD    = 3'd1,
        XFER_HI = 3'd2,
        XFER_LO = 3'd3,
        TRAIL   = 3'd4,
        FINISH  = 3'd5
    } spi_state_t;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int unsigned spi_clog2(input int unsigned value);
        int unsigned width;
        width = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                width = i + 1;
            end
        end
        return width;
    endfunction

endpackage

// File: rtl/spi_clk_tick.sv
// Half-period counter for the SPI master.
// Emits a one-cycle tick on every DIV-th enabled cycle and wraps to 0 on
// that tick, so each FSM phase lasts exactly DIV cycles.
// Ports:
//   clk   - system clock
//   rst   - asynchronous active-high reset
//   en    - count enable
//   clr   - synchronous clear (wins over en)
//   tick  - high on the last cycle of a half period
module spi_clk_tick
    import spi_pkg::*;
#(
    parameter int unsigned DIV = SPI_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned    W    = spi_clog2(DIV) + 1;
    localparam logic [W-1:0]   LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/spi_master.sv
// SPI master, mode 0 (CPOL=0, CPHA=0), MSB first.
// A start in IDLE or FINISH latches din, drops ssbar and clocks N bits out
// on mosi while shifting miso into a receive word, which is returned on
// dout with a one-cycle done pulse.
// Optional feature (macro SPI_LOOPBACK_EN): adds a loopback input; when it
// is high at start-accept the receive path captures mosi instead of miso
// for the whole transfer.
// Ports:
//   clk, rst  - clock and asynchronous active-high reset
//   start     - transfer request, sampled only when not busy
//   din       - word to transmit, latched on an accepted start
//   dout      - last received word, updated with done
//   busy      - transfer in progress
//   done      - one-cycle end-of-transfer pulse
//   sclk      - SPI clock, idle low
//   mosi      - SPI data out
//   miso      - SPI data in
//   loopback  - internal loopback select (SPI_LOOPBACK_EN only)
//   ssbar     - active-low slave select
module spi_master
    import spi_pkg::*;
#(
    parameter int unsigned N       = SPI_N,
    parameter int unsigned CLK_DIV = SPI_CLK_DIV
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] din,
    output logic [N-1:0] dout,
    output logic         busy,
    output logic         done,
    output logic         sclk,
    output logic         mosi,
    input  logic         miso,
`ifdef SPI_LOOPBACK_EN
    input  logic         loopback,
`endif
    output logic         ssbar
);

    localparam int unsigned    BW       = spi_clog2(N) + 1;
    localparam logic [BW-1:0]  LAST_BIT = BW'(N - 1);

    spi_state_t    state;
    logic [N-1:0]  tx_sr;
    logic [N-1:0]  rx_sr;
    logic [BW-1:0] bit_cnt;
    logic          tick;
    logic          phase_en;
    logic          cap_bit;

    // The counter only runs while a timed phase is active; in IDLE/FINISH it
    // is held at 0 so LEAD always starts a fresh half period.
    assign phase_en = (state == LEAD) || (state == XFER_HI) ||
                      (state == XFER_LO) || (state == TRAIL);

    spi_clk_tick #(
        .DIV (CLK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (phase_en),
        .clr  (!phase_en),
        .tick (tick)
    );

`ifdef SPI_LOOPBACK_EN
    logic lb_q;
    assign cap_bit = lb_q ? mosi : miso;
`else
    assign cap_bit = miso;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            tx_sr   <= '0;
            rx_sr   <= '0;
            bit_cnt <= '0;
            sclk    <= 1'b0;
            ssbar   <= 1'b1;
            mosi    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            dout    <= '0;
`ifdef SPI_LOOPBACK_EN
            lb_q    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                // FINISH is the done cycle but accepts a start exactly like
                // IDLE, giving a single ssbar-high cycle between transfers.
                IDLE, FINISH: begin
                    if (start) begin
                        tx_sr   <= din;
                        mosi    <= din[N-1];
                        ssbar   <= 1'b0;
                        busy    <= 1'b1;
                        bit_cnt <= '0;
`ifdef SPI_LOOPBACK_EN
                        lb_q    <= loopback;
`endif
                        state   <= LEAD;
                    end else begin
                        state <= IDLE;
                    end
                end
                LEAD, XFER_LO: begin
                    if (tick) begin
                        sclk  <= 1'b1;
                        rx_sr <= {rx_sr[N-2:0], cap_bit};
                        state <= XFER_HI;
                    end
                end
                XFER_HI: begin
                    if (tick) begin
                        sclk    <= 1'b0;
                        bit_cnt <= bit_cnt + BW'(1);
                        if (bit_cnt == LAST_BIT) begin
                            state <= TRAIL;
                        end else begin
                            tx_sr <= {tx_sr[N-2:0], 1'b0};
                            mosi  <= tx_sr[N-2];
                            state <= XFER_LO;
                        end
                    end
                end
                TRAIL: begin
                    if (tick) begin
                        ssbar <= 1'b1;
                        done  <= 1'b1;
                        dout  <= rx_sr;
                        busy  <= 1'b0;
                        state <= FINISH;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: a CLK_DIV=4 instance against a mode-0
// slave model, and a CLK_DIV=1 instance whose receive path sees its own
// mosi (internal loopback when SPI_LOOPBACK_EN is defined, a wire otherwise).
// Cycle counts treat the start-accept edge as cycle 1.
module tb_spi_master;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, start1;
    logic [7:0] din, din1;
    logic [7:0] dout, dout1;
    logic       busy, busy1, done, done1;
    logic       sclk, sclk1, mosi, mosi1, ssbar, ssbar1;
    logic       miso, miso1;
    logic       lb0, lb1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    spi_master #(.N(8), .CLK_DIV(4)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .din      (din),
        .dout     (dout),
        .busy     (busy),
        .done     (done),
        .sclk     (sclk),
        .mosi     (mosi),
        .miso     (miso),
`ifdef SPI_LOOPBACK_EN
        .loopback (lb0),
`endif
        .ssbar    (ssbar)
    );

    spi_master #(.N(8), .CLK_DIV(1)) u_dut1 (
        .clk      (clk),
        .rst      (rst),
        .start    (start1),
        .din      (din1),
        .dout     (dout1),
        .busy     (busy1),
        .done     (done1),
        .sclk     (sclk1),
        .mosi     (mosi1),
        .miso     (miso1),
`ifdef SPI_LOOPBACK_EN
        .loopback (lb1),
`endif
        .ssbar    (ssbar1)
    );

`ifdef SPI_LOOPBACK_EN
    assign miso1 = 1'b0;
`else
    assign miso1 = mosi1;
`endif

    // Mode-0 slave model: first bit valid at ssbar fall, shifts on sclk
    // fall, captures mosi on sclk rise.
    logic [7:0] slv_tx = 8'h00;
    logic [7:0] slv_sr = 8'h00;
    logic [7:0] slv_rx = 8'h00;
    int         rise_cnt = 0;
    logic       ssbar_p = 1'b1;
    logic       sclk_p = 1'b0;

    always @(ssbar or sclk) begin
        if (ssbar_p === 1'b1 && ssbar === 1'b0) begin
            slv_sr   = slv_tx;
            slv_rx   = 8'h00;
            rise_cnt = 0;
        end else if (ssbar === 1'b0 && sclk_p === 1'b1 && sclk === 1'b0) begin
            slv_sr = {slv_sr[6:0], 1'b0};
        end
        if (ssbar === 1'b0 && sclk_p === 1'b0 && sclk === 1'b1) begin
            slv_rx   = {slv_rx[6:0], mosi};
            rise_cnt = rise_cnt + 1;
        end
        ssbar_p = ssbar;
        sclk_p  = sclk;
    end

    assign miso = slv_sr[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one transfer on u_dut; optionally pulses start with a new din at
    // cycle glitch_at. cyc = -1 on timeout.
    task automatic run_xfer(input logic [7:0] d, input int glitch_at,
                            input logic [7:0] glitch_din, output int cyc, output int low);
        din   = d;
        start = 1'b1;
        cyc   = 0;
        low   = 0;
        forever begin
            tick();
            cyc++;
            start = 1'b0;
            if (cyc == glitch_at) begin
                start = 1'b1;
                din   = glitch_din;
            end
            if (ssbar === 1'b0) low++;
            if (done === 1'b1) break;
            if (cyc >= 300) begin
                cyc = -1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int n;
        int seen_done;
        int lows;
        rst = 1'b1; start = 1'b0; start1 = 1'b0; din = 8'h00; din1 = 8'h00;
        lb0 = 1'b0; lb1 = 1'b0;
        #1;
        checks++; if (ssbar !== 1'b1) begin errors++; $display("FAIL reset_ssbar got=%b exp=1", ssbar); end
        checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk got=%b exp=0", sclk); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got=%b%b exp=00", busy, done); end
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout got=%h exp=00", dout); end
        repeat (3) tick();
        rst = 1'b0;
        repeat (3) tick();
        // Mid-idle reset pulse.
        #1 rst = 1'b1;
        #1;
        checks++; if (ssbar !== 1'b1 || sclk !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL idle_reset got ssbar/sclk/busy/done=%b%b%b%b exp=1000", ssbar, sclk, busy, done);
        end
        tick();
        rst = 1'b0;
        tick();
        // Mid-transfer reset after the third sclk rise.
        slv_tx = 8'hFF;
        din    = 8'hC3;
        start  = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (rise_cnt < 3 && n < 200) begin
            tick();
            n++;
        end
        checks++; if (n >= 200) begin errors++; $display("FAIL xfer_reset_reach got=%0d rises exp=3", rise_cnt); end
        checks++; if (busy !== 1'b1 || ssbar !== 1'b0) begin errors++; $display("FAIL xfer_reset_active got busy/ssbar=%b%b exp=10", busy, ssbar); end
        #1 rst = 1'b1;
        #1;
        checks++; if (ssbar !== 1'b1 || sclk !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL xfer_reset_now got ssbar/sclk/busy/done=%b%b%b%b exp=1000", ssbar, sclk, busy, done);
        end
        tick();
        rst = 1'b0;
        seen_done = 0;
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (done === 1'b1) seen_done++;
            if (ssbar === 1'b0) lows++;
        end
        checks++; if (seen_done != 0 || lows != 0) begin errors++; $display("FAIL xfer_reset_quiet got done=%0d low=%0d exp=0,0", seen_done, lows); end
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL xfer_reset_dout got=%h exp=00", dout); end
    endtask

    task automatic test_single();
        int cyc, low;
        slv_tx = 8'h01;
        run_xfer(8'h12, -1, 8'h00, cyc, low);
        checks++; if (cyc != 69) begin errors++; $display("FAIL single_done_cycle got=%0d exp=69", cyc); end
        checks++; if (dout !== 8'h01) begin errors++; $display("FAIL single_dout got=%h exp=01", dout); end
        checks++; if (slv_rx !== 8'h12) begin errors++; $display("FAIL single_mosi_bits got=%b exp=00010010", slv_rx); end
        checks++; if (rise_cnt != 8) begin errors++; $display("FAIL single_rises got=%0d exp=8", rise_cnt); end
        checks++; if (low != 68) begin errors++; $display("FAIL single_ssbar_low got=%0d exp=68", low); end
        checks++; if (busy !== 1'b0 || ssbar !== 1'b1) begin errors++; $display("FAIL single_end got busy/ssbar=%b%b exp=01", busy, ssbar); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_done_width got=%b exp=0", done); end
    endtask

    task automatic test_second();
        int cyc, low;
        slv_tx = 8'd20;
        run_xfer(8'd55, -1, 8'h00, cyc, low);
        checks++; if (cyc != 69) begin errors++; $display("FAIL second_done_cycle got=%0d exp=69", cyc); end
        checks++; if (dout !== 8'h14) begin errors++; $display("FAIL second_dout got=%h exp=14", dout); end
        checks++; if (slv_rx !== 8'h37) begin errors++; $display("FAIL second_mosi_bits got=%b exp=00110111", slv_rx); end
        repeat (5) tick();
        checks++; if (mosi !== 1'b1) begin errors++; $display("FAIL mosi_hold got=%b exp=1", mosi); end
    endtask

    task automatic test_start_while_busy();
        int cyc, low;
        slv_tx = 8'h9C;
        run_xfer(8'h6A, 20, 8'hFF, cyc, low);
        checks++; if (cyc != 69) begin errors++; $display("FAIL busy_start_done_cycle got=%0d exp=69", cyc); end
        checks++; if (slv_rx !== 8'h6A) begin errors++; $display("FAIL busy_start_mosi got=%h exp=6a", slv_rx); end
        checks++; if (dout !== 8'h9C) begin errors++; $display("FAIL busy_start_dout got=%h exp=9c", dout); end
        repeat (10) tick();
        checks++; if (busy !== 1'b0 || ssbar !== 1'b1) begin errors++; $display("FAIL busy_start_no_restart got busy/ssbar=%b%b exp=01", busy, ssbar); end
    endtask

    task automatic test_back_to_back();
        int cyc, d1, d2, hi;
        logic [7:0] rx1;
        slv_tx = 8'h5B;
        din    = 8'h81;
        start  = 1'b1;
        cyc = 0; d1 = 0; d2 = 0; hi = 0; rx1 = 8'h00;
        while (cyc < 400) begin
            tick();
            cyc++;
            if (cyc == 2) din = 8'h42;
            if (d1 != 0 && cyc == d1 + 1) start = 1'b0;
            if (done === 1'b1 && d1 != 0) begin
                d2 = cyc;
                break;
            end
            if (done === 1'b1) begin
                d1  = cyc;
                rx1 = slv_rx;
            end
            if (d1 != 0 && ssbar === 1'b1) hi++;
        end
        start = 1'b0;
        checks++; if (d1 != 69) begin errors++; $display("FAIL b2b_first_done got=%0d exp=69", d1); end
        checks++; if (d2 - d1 != 69) begin errors++; $display("FAIL b2b_done_spacing got=%0d exp=69", d2 - d1); end
        checks++; if (hi != 1) begin errors++; $display("FAIL b2b_ssbar_gap got=%0d exp=1", hi); end
        checks++; if (rx1 !== 8'h81) begin errors++; $display("FAIL b2b_first_mosi got=%h exp=81", rx1); end
        checks++; if (slv_rx !== 8'h42) begin errors++; $display("FAIL b2b_second_mosi got=%h exp=42", slv_rx); end
        checks++; if (dout !== 8'h5B) begin errors++; $display("FAIL b2b_second_dout got=%h exp=5b", dout); end
        repeat (3) tick();
    endtask

    task automatic test_clkdiv1();
        int cyc, nrise, bad, low, last_rise;
        logic prev;
        lb1    = 1'b1;
        din1   = 8'hA5;
        start1 = 1'b1;
        cyc = 0; nrise = 0; bad = 0; low = 0; last_rise = 0; prev = 1'b0;
        forever begin
            tick();
            cyc++;
            start1 = 1'b0;
            lb1    = 1'b0;
            if (sclk1 === 1'b1 && prev === 1'b0) begin
                if (nrise != 0 && cyc - last_rise != 2) bad++;
                last_rise = cyc;
                nrise++;
            end
            prev = sclk1;
            if (ssbar1 === 1'b0) low++;
            if (done1 === 1'b1) break;
            if (cyc >= 100) begin
                cyc = -1;
                break;
            end
        end
        checks++; if (cyc != 18) begin errors++; $display("FAIL div1_done_cycle got=%0d exp=18", cyc); end
        checks++; if (dout1 !== 8'hA5) begin errors++; $display("FAIL div1_dout got=%h exp=a5", dout1); end
        checks++; if (nrise != 8 || bad != 0) begin errors++; $display("FAIL div1_sclk got rises=%0d bad_periods=%0d exp=8,0", nrise, bad); end
        checks++; if (low != 17) begin errors++; $display("FAIL div1_ssbar_low got=%0d exp=17", low); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_second();
        test_start_while_busy();
        test_back_to_back();
        test_clkdiv1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
